// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: instruction fields and ALU flag in, ALU/datapath strobes and debug out.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic [2:0]       alu_op;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             ext_zero;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, funct, zero,
        output alu_op, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               illegal, retired, state
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_op, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               illegal, retired, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EX     = 4'd10,
        I_WB     = 4'd11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_comb begin
        state_d        = FETCH;
        bus.alu_op     = 3'b000;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.ext_zero   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.pc_en      = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal    = 1'b0;
        retire         = 1'b0;

        unique case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_en     = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                unique case (bus.opcode)
                    6'b000000:                   state_d = R_EX;
                    6'b100011, 6'b101011:        state_d = MEM_ADDR;
                    6'b000100:                   state_d = BRANCH;
                    6'b000010:                   state_d = JUMP;
                    6'b001000, 6'b001100, 6'b001101,
                    6'b001110, 6'b001111:        state_d = I_EX;
                    default:                     bus.illegal = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == 6'b100011) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                state_d      = MEM_WB;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                retire        = 1'b1;
            end
            R_EX: begin
                bus.alu_src_a = 1'b1;
                state_d       = R_WB;
                unique case (bus.funct)
                    6'b100000: bus.alu_op = 3'b000;
                    6'b100010: bus.alu_op = 3'b100;
                    6'b100100: bus.alu_op = 3'b001;
                    6'b100101: bus.alu_op = 3'b101;
                    6'b100110: bus.alu_op = 3'b010;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = FETCH;
                    end
                endcase
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b100;
                bus.pc_src    = 2'b01;
                bus.pc_en     = bus.zero;
                retire        = 1'b1;
            end
            JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
                retire     = 1'b1;
            end
            I_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ext_zero  = 1'b1;
                state_d       = I_WB;
                unique case (bus.opcode)
                    6'b001100: bus.alu_op = 3'b001;
                    6'b001101: bus.alu_op = 3'b101;
                    6'b001110: bus.alu_op = 3'b010;
                    6'b001111: bus.alu_op = 3'b110;
                    default:   bus.ext_zero = 1'b0;
                endcase
            end
            I_WB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Strobes are squelched for the whole reset window, not just from the next edge.
        if (rst) begin
            bus.alu_op     = 3'b000;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = 2'b00;
            bus.ext_zero   = 1'b0;
            bus.pc_src     = 2'b00;
            bus.pc_en      = 1'b0;
            bus.iord       = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
            bus.illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, corner-case sequences and
// randomized instruction streams against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aop;
        logic       sa;
        logic [1:0] sb;
        logic       ez;
        logic [1:0] ps;
        logic       pe;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
    } ctl_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cyc;
        logic [2:0] aop3;
        logic       pe3;
        bit         ret;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         tests = 0;
    int         fails = 0;
    logic [CW-1:0] exp_ret;
    int         phases[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t act_ctl();
        ctl_t c;
        c.st = bus.state;       c.aop = bus.alu_op;    c.sa = bus.alu_src_a;
        c.sb = bus.alu_src_b;   c.ez = bus.ext_zero;   c.ps = bus.pc_src;
        c.pe = bus.pc_en;       c.iord = bus.iord;     c.mr = bus.mem_read;
        c.mw = bus.mem_write;   c.irw = bus.ir_write;  c.rw = bus.reg_write;
        c.rd = bus.reg_dst;     c.m2r = bus.mem_to_reg; c.ill = bus.illegal;
        return c;
    endfunction

    function automatic bit r_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};
    endfunction

    function automatic logic [2:0] r_aop(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b100;
            6'b100100: return 3'b001;
            6'b100101: return 3'b101;
            6'b100110: return 3'b010;
            default:   return 3'b000;
        endcase
    endfunction

    // Cycle-by-cycle path an instruction takes, plus whether it retires.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, output bit ret);
        phases = {0, 1};
        ret = 1'b1;
        case (op)
            6'b000000: if (r_ok(fn)) phases = {phases, 6, 7};
                       else begin phases.push_back(6); ret = 1'b0; end
            6'b100011: phases = {phases, 2, 3, 4};
            6'b101011: phases = {phases, 2, 5};
            6'b000100: phases.push_back(8);
            6'b000010: phases.push_back(9);
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111:
                       phases = {phases, 10, 11};
            default:   ret = 1'b0;
        endcase
    endtask

    function automatic ctl_t model_ctl(input int ph, input logic [5:0] op,
                                       input logic [5:0] fn, input logic z);
        ctl_t c = '0;
        c.st = 4'(ph);
        case (ph)
            0:  begin c.mr = 1; c.irw = 1; c.sb = 2'b01; c.pe = 1; end
            1:  begin
                    c.sb  = 2'b11;
                    c.ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                         6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111});
                end
            2:  begin c.sa = 1; c.sb = 2'b10; end
            3:  begin c.mr = 1; c.iord = 1; end
            4:  begin c.rw = 1; c.m2r = 1; end
            5:  begin c.mw = 1; c.iord = 1; end
            6:  begin c.sa = 1; c.aop = r_aop(fn); c.ill = !r_ok(fn); end
            7:  begin c.rw = 1; c.rd = 1; end
            8:  begin c.sa = 1; c.aop = 3'b100; c.ps = 2'b01; c.pe = z; end
            9:  begin c.ps = 2'b10; c.pe = 1; end
            10: begin
                    c.sa = 1; c.sb = 2'b10;
                    case (op)
                        6'b001100: begin c.aop = 3'b001; c.ez = 1; end
                        6'b001101: begin c.aop = 3'b101; c.ez = 1; end
                        6'b001110: begin c.aop = 3'b010; c.ez = 1; end
                        6'b001111: begin c.aop = 3'b110; c.ez = 1; end
                        default:   c.aop = 3'b000;
                    endcase
                end
            11: c.rw = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Entered and left at a negedge with the DUT in FETCH.
    task automatic run_model(input logic [5:0] op, input logic [5:0] fn, input bit rand_zero);
        bit ret;
        bus.opcode = op;
        bus.funct  = fn;
        build(op, fn, ret);
        for (int i = 0; i < phases.size(); i++) begin
            if (rand_zero) begin
                bus.zero = 1'($urandom_range(0, 1));
                #1;
            end
            chk("ctl", 32'(act_ctl()), 32'(model_ctl(phases[i], op, fn, bus.zero)));
            @(posedge clk);
            @(negedge clk);
        end
        if (ret) exp_ret++;
        chk("next_fetch", 32'(bus.state), 32'd0);
        chk("retired", 32'(bus.retired), 32'(exp_ret));
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        logic [2:0] a3 = 3'b000;
        logic       p3 = 1'b0;
        bus.opcode = v.op;
        bus.funct  = v.fn;
        bus.zero   = v.z;
        do begin
            if (n == 2) begin
                a3 = bus.alu_op;
                p3 = bus.pc_en;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (bus.state != 4'd0 && n < 12);
        chk({v.name, "_cycles"}, 32'(n), 32'(v.cyc));
        if (v.cyc >= 3) begin
            chk({v.name, "_aop3"}, 32'(a3), 32'(v.aop3));
            chk({v.name, "_pe3"}, 32'(p3), 32'(v.pe3));
        end
        if (v.ret) exp_ret++;
        chk({v.name, "_retired"}, 32'(bus.retired), 32'(exp_ret));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_ret = '0;
        @(negedge clk);
    endtask

    vec_t vecs[$];
    logic [5:0] ops[10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    logic [5:0] fns[5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};

    initial begin
        vecs = '{
            '{"add",  6'b000000, 6'b100000, 1'b0, 4, 3'b000, 1'b0, 1'b1},
            '{"sub",  6'b000000, 6'b100010, 1'b0, 4, 3'b100, 1'b0, 1'b1},
            '{"and",  6'b000000, 6'b100100, 1'b0, 4, 3'b001, 1'b0, 1'b1},
            '{"or",   6'b000000, 6'b100101, 1'b0, 4, 3'b101, 1'b0, 1'b1},
            '{"xor",  6'b000000, 6'b100110, 1'b0, 4, 3'b010, 1'b0, 1'b1},
            '{"beq1", 6'b000100, 6'b000000, 1'b1, 3, 3'b100, 1'b1, 1'b1},
            '{"beq0", 6'b000100, 6'b000000, 1'b0, 3, 3'b100, 1'b0, 1'b1},
            '{"lui",  6'b001111, 6'b000000, 1'b0, 4, 3'b110, 1'b0, 1'b1},
            '{"addi", 6'b001000, 6'b000000, 1'b0, 4, 3'b000, 1'b0, 1'b1},
            '{"andi", 6'b001100, 6'b000000, 1'b0, 4, 3'b001, 1'b0, 1'b1},
            '{"ori",  6'b001101, 6'b000000, 1'b0, 4, 3'b101, 1'b0, 1'b1},
            '{"xori", 6'b001110, 6'b000000, 1'b0, 4, 3'b010, 1'b0, 1'b1},
            '{"sw",   6'b101011, 6'b000000, 1'b0, 4, 3'b000, 1'b0, 1'b1},
            '{"lw",   6'b100011, 6'b000000, 1'b0, 5, 3'b000, 1'b0, 1'b1},
            '{"j",    6'b000010, 6'b000000, 1'b0, 3, 3'b000, 1'b1, 1'b1},
            '{"badop",6'b111111, 6'b000000, 1'b0, 2, 3'b000, 1'b0, 1'b0},
            '{"badfn",6'b000000, 6'b000000, 1'b0, 3, 3'b000, 1'b0, 1'b0}
        };

        rst = 1'b1;
        bus.opcode = '0;
        bus.funct  = '0;
        bus.zero   = 1'b0;
        exp_ret    = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_ctl", 32'(act_ctl()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_fetch", 32'(act_ctl()), 32'(model_ctl(0, 6'd0, 6'd0, 1'b0)));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-lw, then a clean lw afterwards
        bus.opcode = 6'b100011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lw_memrd_state", 32'(bus.state), 32'd3);
        chk("lw_memrd_read", 32'(bus.mem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(bus.state), 32'd0);
        chk("midrst_read", 32'(bus.mem_read), 32'd0);
        chk("midrst_ctl", 32'(act_ctl()), 32'd0);
        exp_ret = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        run_model(6'b100011, 6'd0, 1'b0);
        chk("lw_after_rst_retired", 32'(bus.retired), 32'd1);

        // beq with zero toggling inside BRANCH
        bus.opcode = 6'b000100;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("beq_state", 32'(bus.state), 32'd8);
        bus.zero = 1'b1; #1;
        chk("beq_pe_z1", 32'(bus.pc_en), 32'd1);
        chk("beq_pcsrc", 32'(bus.pc_src), 32'd1);
        bus.zero = 1'b0; #1;
        chk("beq_pe_z0", 32'(bus.pc_en), 32'd0);
        bus.zero = 1'b1; #1;
        chk("beq_pe_z1b", 32'(bus.pc_en), 32'd1);
        @(posedge clk);
        @(negedge clk);
        exp_ret++;
        chk("beq_done_state", 32'(bus.state), 32'd0);
        chk("beq_retired", 32'(bus.retired), 32'(exp_ret));

        // Illegal opcode: one DECODE cycle flagged, straight back to FETCH
        bus.opcode = 6'b111111;
        @(posedge clk);
        @(negedge clk);
        chk("badop_ill", 32'(bus.illegal), 32'd1);
        chk("badop_state", 32'(bus.state), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("badop_back", 32'(bus.state), 32'd0);
        chk("badop_ill_clr", 32'(bus.illegal), 32'd0);
        chk("badop_retired", 32'(bus.retired), 32'(exp_ret));

        // Illegal funct flagged in R_EX
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        @(posedge clk);
        @(negedge clk);
        chk("badfn_dec_ill", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("badfn_rex_state", 32'(bus.state), 32'd6);
        chk("badfn_rex_ill", 32'(bus.illegal), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("badfn_back", 32'(bus.state), 32'd0);
        chk("badfn_retired", 32'(bus.retired), 32'(exp_ret));

        // 4-bit counter wraps after 16 retirements
        reset_pulse();
        for (int i = 0; i < 16; i++) run_model(6'b000010, 6'd0, 1'b0);
        chk("wrap", 32'(bus.retired), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_model(op, fn, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
